// File: rtl/fpu_dispatch_pkg.sv
// Shared types and defaults for the FPU dispatcher: op codes, FSM states,
// the writeback payload and the default in-flight depth and timeout.
package fpu_dispatch_pkg;

    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned NUM_OPS     = 8;
    localparam int unsigned TAG_W       = 6;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [OP_W-1:0] {
        OP_FADD  = 3'd0,
        OP_FSUB  = 3'd1,
        OP_FMUL  = 3'd2,
        OP_FDIV  = 3'd3,
        OP_FSQRT = 3'd4,
        OP_FTOI  = 3'd5,
        OP_ITOF  = 3'd6,
        OP_FABS  = 3'd7
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    function automatic logic [NUM_OPS-1:0] op_onehot(input logic [OP_W-1:0] op);
        return NUM_OPS'(1) << op;
    endfunction

endpackage

// File: rtl/fpu_dispatch_tag_fifo.sv
// Synchronous tag FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, and flush empties it.
module tag_fifo
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned W     = TAG_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 head_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_c = (cnt_q == '0);
    assign full_c  = (cnt_q == CNT_W'(DEPTH));
    assign head_c  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_c;
    assign do_push = push_i && (!full_c || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Issues CPU floating-point ops to the FPU one op class at a time, tracks
// destination tags in order, writes results back and faults on lost/spurious results.
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [TAG_W-1:0]    req_rd,
    input  logic [DATA_W-1:0]   req_x1,
    input  logic [DATA_W-1:0]   req_x2,
    output logic [NUM_OPS-1:0]  fpu_opcode,
    output logic [DATA_W-1:0]   fpu_x1,
    output logic [DATA_W-1:0]   fpu_x2,
    input  logic [DATA_W-1:0]   fpu_y,
    input  logic                fpu_out_valid,
    output logic                wb_valid,
    output logic [TAG_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                err,
    input  logic                clr_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    fpu_op_e              last_op_q, last_op_d;
    logic [NUM_OPS-1:0]   opc_q, opc_d;
    logic [DATA_W-1:0]    x1_q, x1_d;
    logic [DATA_W-1:0]    x2_q, x2_d;
    logic                 wbv_q, wbv_d;
    wb_t                  wb_q, wb_d;
    logic                 err_q, err_d;

    logic [TAG_W-1:0]     fifo_head_c;
    logic                 fifo_full_c;
    logic                 fifo_empty_c;
    logic [CNT_W-1:0]     fifo_count;
    logic                 issue;
    logic                 pop;
    logic                 spurious;
    logic                 flush;

    // Same-class ops only stack up, so results come back in issue order.
    assign req_ready = (state_q != ST_FAULT) &&
                       (fifo_empty_c || ((req_op == last_op_q) && !fifo_full_c));
    assign issue     = req_valid && req_ready;
    assign spurious  = fpu_out_valid && fifo_empty_c;
    assign pop       = fpu_out_valid && !fifo_empty_c && (state_q != ST_FAULT);
    assign flush     = (state_d == ST_FAULT);

    tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk_i   (sys_clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (issue),
        .pop_i   (pop),
        .data_i  (req_rd),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        last_op_d = last_op_q;
        opc_d     = '0;
        x1_d      = x1_q;
        x2_d      = x2_q;
        wbv_d     = 1'b0;
        wb_d      = wb_q;

        case (state_q)
            ST_IDLE: begin
                if (spurious)   state_d = ST_FAULT;
                else if (issue) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (spurious)
                    state_d = ST_FAULT;
                else if (!issue && !pop && (wdog_q == WD_W'(TIMEOUT - 1)))
                    state_d = ST_FAULT;
                else if (pop && !issue && (fifo_count == CNT_W'(1)))
                    state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clr_err) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        wdog_d = ((state_q == ST_BUSY) && !issue && !pop) ? wdog_q + WD_W'(1) : '0;

        if (issue) begin
            last_op_d = fpu_op_e'(req_op);
            x1_d      = req_x1;
            x2_d      = req_x2;
            if (!spurious) opc_d = op_onehot(req_op);
        end

        if (pop) begin
            wbv_d   = 1'b1;
            wb_d.rd   = fifo_head_c;
            wb_d.data = fpu_y;
        end

        err_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wdog_q    <= '0;
            last_op_q <= OP_FADD;
            opc_q     <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            wbv_q     <= 1'b0;
            wb_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            last_op_q <= last_op_d;
            opc_q     <= opc_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            wbv_q     <= wbv_d;
            wb_q      <= wb_d;
            err_q     <= err_d;
        end
    end

    assign fpu_opcode = opc_q;
    assign fpu_x1     = x1_q;
    assign fpu_x2     = x2_q;
    assign wb_valid   = wbv_q;
    assign wb_rd      = wb_q.rd;
    assign wb_data    = wb_q.data;
    assign err        = err_q;

endmodule
